ft_fifo_tx_writer: RTL and testbench

- Drain side of the USB byte path: pops bytes from the on-chip byte queue and writes them to the external FT245-style asynchronous FIFO chip.
- The chip write side uses an active-low write strobe `wr_n`, a tri-state data bus and an active-low "TX space available" flag `txe_n`.
- Generates programmable setup, strobe, hold and recovery timing.
- Sits between the queue read port (`empty`, `read_success`, `data_out`) and the device pins.

---
 rtl/ft_fifo_tx_writer_pkg.sv | 32 +++
 rtl/ft_fifo_tx_writer_sync_2ff.sv | 24 ++
 rtl/ft_fifo_tx_writer.sv | 118 +++++++++++
 tb/tb_ft_fifo_tx_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_fifo_tx_writer_pkg.sv
// Shared types and timing defaults for the USB byte-path transmit writer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } tx_state_t;

  localparam int TCNT_W       = 4;
  localparam int TCNT_MAX     = (1 << TCNT_W) - 1;

  localparam int DEF_SETUP    = 2;
  localparam int DEF_PULSE    = 3;
  localparam int DEF_HOLD     = 1;
  localparam int DEF_RECOVER  = 4;

  // Phase length clamped to [min_cyc, TCNT_MAX], returned as the counter preload (length - 1).
  function automatic logic [TCNT_W-1:0] phase_load(input int unsigned cyc,
                                                   input int unsigned min_cyc);
    int unsigned c;
    c = cyc;
    if (c < min_cyc) c = min_cyc;
    if (c > TCNT_MAX) c = TCNT_MAX;
    return TCNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/ft_fifo_tx_writer_sync_2ff.sv
// Two-flop synchroniser for asynchronous active-low chip flags; resets to all ones (inactive).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ft_fifo_tx_writer.sv
// Pops bytes from the on-chip queue and writes them to an FT245-style FIFO chip
// with programmable setup / strobe / hold / recovery timing.
module ft_fifo_tx_writer
  import usb_tx_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP,
  parameter int PULSE_CYC   = DEF_PULSE,
  parameter int HOLD_CYC    = DEF_HOLD,
  parameter int RECOVER_CYC = DEF_RECOVER,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             src_empty,
  input  logic [7:0]       src_data,
  output logic             src_rd,
  input  logic             txe_n,
  output logic             wr_n,
  output logic [7:0]       d_out,
  output logic             d_oe,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam logic [TCNT_W-1:0] SETUP_LD   = phase_load(SETUP_CYC, 1);
  localparam logic [TCNT_W-1:0] PULSE_LD   = phase_load(PULSE_CYC, 1);
  localparam logic [TCNT_W-1:0] HOLD_LD    = phase_load(HOLD_CYC, 1);
  localparam logic [TCNT_W-1:0] RECOVER_LD = phase_load(RECOVER_CYC, 2);

  tx_state_t         state;
  logic [TCNT_W-1:0] tcnt;
  logic              txe_s;

  sync_2ff #(.W(1)) u_txe_sync (
    .clk (clk),
    .rst (rst),
    .d   (txe_n),
    .q   (txe_s)
  );

  // Write sequencer: state, shared phase counter and all registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      src_rd   <= 1'b0;
      wr_n     <= 1'b1;
      d_out    <= '0;
      d_oe     <= 1'b0;
      busy     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      src_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && !src_empty && !txe_s) begin
            state  <= S_REQ;
            src_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          d_out <= src_data;
          d_oe  <= 1'b1;
          tcnt  <= SETUP_LD;
          state <= S_SETUP;
        end
        S_SETUP: begin
          if (tcnt == '0) begin
            wr_n  <= 1'b0;
            tcnt  <= PULSE_LD;
            state <= S_STROBE;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end
        S_STROBE: begin
          if (tcnt == '0) begin
            wr_n     <= 1'b1;
            sent_cnt <= sent_cnt + CNT_W'(1);
            tcnt     <= HOLD_LD;
            state    <= S_HOLD;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end
        S_HOLD: begin
          if (tcnt == '0) begin
            d_oe  <= 1'b0;
            tcnt  <= RECOVER_LD;
            state <= S_RECOVER;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end
        S_RECOVER: begin
          if (tcnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end
        default: begin
          wr_n  <= 1'b1;
          d_oe  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft_fifo_tx_writer.sv
// Directed bench for ft_fifo_tx_writer with a simple byte-queue model on the read side.
module tb_ft_fifo_tx_writer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        src_empty;
  logic [7:0]  src_data;
  logic        src_rd;
  logic        txe_n;
  logic        wr_n;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        busy;
  logic [15:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  ft_fifo_tx_writer #(
    .SETUP_CYC   (2),
    .PULSE_CYC   (3),
    .HOLD_CYC    (1),
    .RECOVER_CYC (4),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .src_empty (src_empty),
    .src_data  (src_data),
    .src_rd    (src_rd),
    .txe_n     (txe_n),
    .wr_n      (wr_n),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .busy      (busy),
    .sent_cnt  (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte queue model: data appears the clock after a pop.
  logic [7:0]  qmem [0:63];
  int unsigned qh = 0;
  int unsigned qt = 0;
  assign src_empty = (qh == qt);

  initial src_data = 8'h00;
  always @(posedge clk) begin
    if (src_rd) begin
      src_data <= qmem[qh % 64];
      qh       <= qh + 1;
    end
  end

  // Observation log sampled on the falling edge.
  int          cyc = 0;
  int          rd_cnt = 0;
  int          inv_err = 0;
  int          sn = 0;
  logic [7:0]  sv [0:63];
  int          sc [0:63];
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (src_rd) rd_cnt = rd_cnt + 1;
    if (src_rd && prev_rd) inv_err = inv_err + 1;
    if (!wr_n && !d_oe) inv_err = inv_err + 1;
    if (!wr_n && prev_wr) begin
      sv[sn % 64] = d_out;
      sc[sn % 64] = cyc;
      sn = sn + 1;
    end
    prev_rd = src_rd;
    prev_wr = wr_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    qmem[qt % 64] = v;
    qt = qt + 1;
  endtask

  task automatic wait_rd();
    int k = 0;
    while (!src_rd && k < 60) begin
      step();
      k++;
    end
    chk("rd_seen", {31'd0, src_rd}, 32'd1);
  endtask

  task automatic wait_sent(input logic [15:0] v);
    int k = 0;
    while (sent_cnt != v && k < 200) begin
      step();
      k++;
    end
    chk("sent_reach", {16'd0, sent_cnt}, {16'd0, v});
  endtask

  int r0;
  int s0;

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    txe_n = 1'b1;
    step(3);
    chk("rst_wr_n", {31'd0, wr_n}, 32'd1);
    chk("rst_d_oe", {31'd0, d_oe}, 32'd0);
    chk("rst_d_out", {24'd0, d_out}, 32'h0);
    chk("rst_src_rd", {31'd0, src_rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sent", {16'd0, sent_cnt}, 32'd0);
    rst = 1'b0;

    // Basic write of 0xA5.
    push(8'hA5);
    en    = 1'b1;
    txe_n = 1'b0;
    wait_rd();
    chk("b_busy_req", {31'd0, busy}, 32'd1);
    chk("b_doe_req", {31'd0, d_oe}, 32'd0);
    step();
    chk("b_rd_one", {31'd0, src_rd}, 32'd0);
    chk("b_doe_load", {31'd0, d_oe}, 32'd0);
    step();
    chk("b_doe_rise", {31'd0, d_oe}, 32'd1);
    chk("b_dout", {24'd0, d_out}, 32'hA5);
    chk("b_wr_setup0", {31'd0, wr_n}, 32'd1);
    step();
    chk("b_wr_setup1", {31'd0, wr_n}, 32'd1);
    step();
    chk("b_wr_low0", {31'd0, wr_n}, 32'd0);
    step();
    chk("b_wr_low1", {31'd0, wr_n}, 32'd0);
    step();
    chk("b_wr_low2", {31'd0, wr_n}, 32'd0);
    step();
    chk("b_wr_hold", {31'd0, wr_n}, 32'd1);
    chk("b_sent", {16'd0, sent_cnt}, 32'd1);
    chk("b_doe_hold", {31'd0, d_oe}, 32'd1);
    step();
    chk("b_doe_rec", {31'd0, d_oe}, 32'd0);
    chk("b_dout_keep", {24'd0, d_out}, 32'hA5);
    chk("b_busy_rec", {31'd0, busy}, 32'd1);
    step(3);
    chk("b_busy_rec_end", {31'd0, busy}, 32'd1);
    step();
    chk("b_busy_idle", {31'd0, busy}, 32'd0);
    chk("b_rd_cnt", rd_cnt, 32'd1);

    // Back-to-back 0x01, 0x02, 0x03.
    s0 = sn;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_sent(16'd4);
    step(20);
    chk("bb_strobes", sn - s0, 32'd3);
    chk("bb_v0", {24'd0, sv[s0 % 64]}, 32'h01);
    chk("bb_v1", {24'd0, sv[(s0 + 1) % 64]}, 32'h02);
    chk("bb_v2", {24'd0, sv[(s0 + 2) % 64]}, 32'h03);
    chk("bb_gap0", sc[(s0 + 1) % 64] - sc[s0 % 64], 32'd13);
    chk("bb_gap1", sc[(s0 + 2) % 64] - sc[(s0 + 1) % 64], 32'd13);
    chk("bb_rd_cnt", rd_cnt, 32'd4);
    chk("bb_busy", {31'd0, busy}, 32'd0);

    // Back-pressure: no activity while chip reports full.
    txe_n = 1'b1;
    step(3);
    push(8'h5A);
    r0 = rd_cnt;
    s0 = sn;
    step(50);
    chk("bp_no_rd", rd_cnt, r0);
    chk("bp_no_strobe", sn, s0);
    chk("bp_wr_n", {31'd0, wr_n}, 32'd1);
    txe_n = 1'b0;
    step(2);
    chk("bp_rd_early", {31'd0, src_rd}, 32'd0);
    step();
    chk("bp_rd_3clk", {31'd0, src_rd}, 32'd1);
    step(14);
    chk("bp_sent", {16'd0, sent_cnt}, 32'd5);
    chk("bp_val", {24'd0, sv[(sn - 1) % 64]}, 32'h5A);

    // txe_n rises during SETUP: byte still completes, next one waits.
    push(8'h3C);
    wait_rd();
    step(2);
    txe_n = 1'b1;
    push(8'h77);
    step(12);
    chk("mb_sent", {16'd0, sent_cnt}, 32'd6);
    chk("mb_val", {24'd0, sv[(sn - 1) % 64]}, 32'h3C);
    r0 = rd_cnt;
    step(30);
    chk("mb_wait_rd", rd_cnt, r0);
    chk("mb_wait_busy", {31'd0, busy}, 32'd0);
    txe_n = 1'b0;
    wait_sent(16'd7);
    chk("mb_val2", {24'd0, sv[(sn - 1) % 64]}, 32'h77);
    step(8);

    // Enable drop during STROBE.
    r0 = rd_cnt;
    push(8'h99);
    wait_rd();
    step(5);
    chk("en_in_strobe", {31'd0, wr_n}, 32'd0);
    en = 1'b0;
    push(8'h42);
    step(40);
    chk("en_sent", {16'd0, sent_cnt}, 32'd8);
    chk("en_val", {24'd0, sv[(sn - 1) % 64]}, 32'h99);
    chk("en_rd_cnt", rd_cnt, r0 + 1);
    chk("en_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during STROBE.
    en = 1'b1;
    wait_rd();
    step(5);
    chk("ar_in_strobe", {31'd0, wr_n}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("ar_wr_n", {31'd0, wr_n}, 32'd1);
    chk("ar_d_oe", {31'd0, d_oe}, 32'd0);
    chk("ar_sent", {16'd0, sent_cnt}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    step(2);
    rst = 1'b0;
    push(8'hE7);
    wait_sent(16'd1);
    chk("ar_val", {24'd0, sv[(sn - 1) % 64]}, 32'hE7);
    step(8);

    chk("invariants", inv_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
